// File: rtl/uart_rx_param.sv
// uart_rx_param - parametrised 16x-oversampling UART receiver.
//
// Receives LSB-first frames (start, DATA_BITS data, optional parity, 1 or 2
// stop bits) from an asynchronous serial line. It presents each good word
// through a held rx_finish flag that rx_ready clears, and it pulses one-cycle
// flags for parity, framing and overrun errors.
//
// Optional build macro: UART_RX_MAJORITY_EN. When defined, each bit value is
// the 2-of-3 vote of the samples at sub-bit ticks 6, 7 and 8. When it is not
// defined, the bit value is the single sample at tick 7. In both builds the
// bit decision is taken on tick 8, so frame latency does not change with the
// macro.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   txd_in       raw serial line, idle high, asynchronous to clk
//   rx_data      last accepted data word (DATA_BITS wide)
//   rx_finish    data valid, held until rx_ready is seen
//   rx_ready     acknowledge from the upper module, clears rx_finish
//   parity_err   one-cycle pulse, parity mismatch
//   frame_err    one-cycle pulse, a stop bit was sampled low
//   overrun_err  one-cycle pulse, a good frame was dropped while rx_finish was high
module uart_rx_param #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 txd_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_finish,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 32'sd16);
    localparam int DIV     = (DIV_RAW < 32'sd2) ? 32'sd2 : DIV_RAW;
    localparam int TCW     = $clog2(DIV);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(DIV - 32'sd1);
    localparam logic [TCW-1:0] TICK_ONE  = TCW'(32'sd1);
    localparam logic [3:0]     BIT_LAST  = 4'(DATA_BITS - 32'sd1);
    localparam logic           HAS_PAR   = (PARITY != 32'sd0);
    localparam logic           EVEN_PAR  = (PARITY == 32'sd2);
    localparam logic           TWO_STOP  = (STOP_BITS == 32'sd2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // XOR of the data word and the received parity bit (1 = odd ones count)
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic pbit);
        return (^data) ^ pbit;
    endfunction

    // 2-of-3 majority vote
    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic                 sync1_r, sync2_r, line_prev_r;
    logic [2:0]           state_r;
    logic [TCW-1:0]       tick_cnt_r;
    logic [3:0]           sub_cnt_r;
    logic [3:0]           bit_cnt_r;
    logic                 stop_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_err_r, frm_err_r;
    logic                 s7_r;
`ifdef UART_RX_MAJORITY_EN
    logic                 s6_r;
    logic                 samp6_s;
`endif
    logic tick_s, fall_s, samp7_s, decide_s, bit_val_s, par_mis_s;
    logic last_stop_s, perr_s, ferr_s, good_s;

    // Two-flop synchroniser plus the edge-detect register; all idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r     <= 1'b1;
            sync2_r     <= 1'b1;
            line_prev_r <= 1'b1;
        end else begin
            sync1_r     <= txd_in;
            sync2_r     <= sync1_r;
            line_prev_r <= sync2_r;
        end
    end

    // Tick strobes, bit-value selection and end-of-frame decode
    always_comb begin
        fall_s   = line_prev_r & ~sync2_r;
        tick_s   = (state_r != ST_IDLE) && (tick_cnt_r == TICK_LAST);
        samp7_s  = tick_s && (sub_cnt_r == 4'd7);
        decide_s = tick_s && (sub_cnt_r == 4'd8);
`ifdef UART_RX_MAJORITY_EN
        samp6_s   = tick_s && (sub_cnt_r == 4'd6);
        // third vote is the live line on tick 8
        bit_val_s = vote3(s6_r, s7_r, sync2_r);
`else
        bit_val_s = s7_r;
`endif
        par_mis_s   = EVEN_PAR ? calc_parity(shift_r, bit_val_s)
                               : ~calc_parity(shift_r, bit_val_s);
        last_stop_s = decide_s && (state_r == ST_STOP) && (!TWO_STOP || stop_cnt_r);
        perr_s      = par_err_r;
        ferr_s      = frm_err_r | ~bit_val_s;
        good_s      = ~perr_s & ~ferr_s;
    end

    // Baud tick divider and sub-bit counter; both held at zero while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= {TCW{1'b0}};
            sub_cnt_r  <= 4'd0;
        end else if (state_r == ST_IDLE) begin
            tick_cnt_r <= {TCW{1'b0}};
            sub_cnt_r  <= 4'd0;
        end else if (tick_s) begin
            tick_cnt_r <= {TCW{1'b0}};
            sub_cnt_r  <= sub_cnt_r + 4'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
        end
    end

    // Capture the early samples that feed the bit decision on tick 8
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s7_r <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            s6_r <= 1'b1;
`endif
        end else begin
            if (samp7_s) begin
                s7_r <= sync2_r;
            end
`ifdef UART_RX_MAJORITY_EN
            if (samp6_s) begin
                s6_r <= sync2_r;
            end
`endif
        end
    end

    // Frame state machine, deserialiser and registered handshake/error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 4'd0;
            stop_cnt_r  <= 1'b0;
            shift_r     <= {DATA_BITS{1'b0}};
            par_err_r   <= 1'b0;
            frm_err_r   <= 1'b0;
            rx_data     <= {DATA_BITS{1'b0}};
            rx_finish   <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            if (rx_finish && rx_ready) begin
                rx_finish <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_r    <= ST_START;
                        bit_cnt_r  <= 4'd0;
                        stop_cnt_r <= 1'b0;
                        par_err_r  <= 1'b0;
                        frm_err_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    // a start bit that is high again at mid-bit is a glitch
                    if (decide_s) begin
                        state_r <= bit_val_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide_s) begin
                        shift_r <= {bit_val_s, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide_s) begin
                        par_err_r <= par_mis_s;
                        state_r   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (last_stop_s) begin
                        // frame is closed at mid stop bit; the tail is not waited out
                        state_r    <= ST_IDLE;
                        parity_err <= perr_s;
                        frame_err  <= ferr_s;
                        if (good_s) begin
                            // a load in the same cycle as an acknowledge wins
                            if (!rx_finish || rx_ready) begin
                                rx_data   <= shift_r;
                                rx_finish <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end
                    end else if (decide_s) begin
                        frm_err_r  <= frm_err_r | ~bit_val_s;
                        stop_cnt_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8O1 instance (a) on the main path and a
// 7E2 instance (b) for the two-stop-bit framing case. 864 clocks per bit.
module tb_uart_rx_param;

    localparam int BIT_CLKS = 864;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line_a, line_b, rdy_a, rdy_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       fin_a, perr_a, ferr_a, ovr_a;
    logic       fin_b, perr_b, ferr_b, ovr_b;

    int n_checks = 0;
    int n_fail   = 0;
    int np_a = 0, nf_a = 0, no_a = 0, np_b = 0, nf_b = 0;
    int bp, bf, bo, bpb, bfb;
    logic    fin_prev_a = 1'b0;
    longint  start_t = 0, rise_t = 0;
    longint  lat;
    logic [15:0] fr;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(100_000_000), .BAUD(115200), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .txd_in(line_a), .rx_data(data_a), .rx_finish(fin_a),
        .rx_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a));

    uart_rx_param #(.CLK_FREQ(100_000_000), .BAUD(115200), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .txd_in(line_b), .rx_data(data_b), .rx_finish(fin_b),
        .rx_ready(rdy_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(ovr_b));

    // pulse counters and rx_finish rise time, sampled away from the active edge
    always @(negedge clk) begin
        if (perr_a) np_a = np_a + 1;
        if (ferr_a) nf_a = nf_a + 1;
        if (ovr_a)  no_a = no_a + 1;
        if (perr_b) np_b = np_b + 1;
        if (ferr_b) nf_b = nf_b + 1;
        if (fin_a && !fin_prev_a) rise_t = $time;
        fin_prev_a = fin_a;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 8-bit frame: start, data LSB first, parity bit p, stop
    function automatic logic [15:0] f8(input logic [7:0] d, input logic p);
        return {5'b11111, 1'b1, p, d, 1'b0};
    endfunction

    // drive bits[0..n-1], one bit time each, changes on the falling clock edge
    task automatic send_bits(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) begin
                line_a = bits[i];
                if (i == 0) start_t = $time;
            end else begin
                line_b = bits[i];
            end
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic ack_a();
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; line_a = 1'b1; line_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst_data",  {24'd0, data_a}, 32'h0);
        check_val("rst_fin",   {31'd0, fin_a}, 32'h0);
        check_val("rst_errs",  {29'd0, perr_a, ferr_a, ovr_a}, 32'h0);
        check_val("rst_fin_b", {31'd0, fin_b}, 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        fork
            begin : path_a
                // good 8O1 frame 0x5A, four ones -> odd parity bit 1
                send_bits(0, f8(8'h5A, 1'b1), 11);
                lat = (rise_t - start_t) / 10;
                check_val("5a_data", {24'd0, data_a}, 32'h5A);
                check_val("5a_fin",  {31'd0, fin_a}, 32'h1);
                // rise at mid stop bit: 10.5 bits (9072 clocks) +/- half a bit
                check_val("5a_latency_window", {31'd0, (lat >= 8640 && lat <= 9504)}, 32'h1);
                ack_a();
                check_val("5a_ack_clear", {31'd0, fin_a}, 32'h0);

                // same data, wrong parity bit
                bp = np_a; bf = nf_a;
                send_bits(0, f8(8'h5A, 1'b0), 11);
                check_val("perr_pulses", np_a - bp, 32'd1);
                check_val("perr_no_ferr", nf_a - bf, 32'd0);
                check_val("perr_fin", {31'd0, fin_a}, 32'h0);
                check_val("perr_data", {24'd0, data_a}, 32'h5A);
            end
            begin : path_b
                repeat (200) @(negedge clk);
                bpb = np_b; bfb = nf_b;
                // 7E2 0x41: two ones -> even parity bit 0; second stop bit low
                send_bits(1, {5'b11111, 1'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 11);
                line_b = 1'b1;
                repeat (50) @(negedge clk);
                check_val("b_ferr_pulses", nf_b - bfb, 32'd1);
                check_val("b_ferr_no_perr", np_b - bpb, 32'd0);
                check_val("b_ferr_fin", {31'd0, fin_b}, 32'h0);
                repeat (BIT_CLKS) @(negedge clk);
                send_bits(1, {5'b11111, 1'b1, 1'b1, 1'b0, 7'h41, 1'b0}, 11);
                check_val("b_data", {25'd0, data_b}, 32'h41);
                check_val("b_fin", {31'd0, fin_b}, 32'h1);
                check_val("b_no_err", (nf_b - bfb) + (np_b - bpb), 32'd1);
            end
        join

        // back-to-back 0x11 then 0x22 without acknowledge -> overrun
        bo = no_a; bp = np_a; bf = nf_a;
        send_bits(0, f8(8'h11, 1'b1), 11);
        send_bits(0, f8(8'h22, 1'b1), 11);
        check_val("ovr_data", {24'd0, data_a}, 32'h11);
        check_val("ovr_fin", {31'd0, fin_a}, 32'h1);
        check_val("ovr_pulses", no_a - bo, 32'd1);
        check_val("ovr_no_err", (np_a - bp) + (nf_a - bf), 32'd0);
        ack_a();

`ifdef UART_RX_MAJORITY_EN
        // 0x00 with a 54-clock high spike inside data bit 3
        bp = np_a;
        fr = f8(8'h00, 1'b1);
        send_bits(0, fr, 4);
        line_a = 1'b0;
        repeat (410) @(negedge clk);
        line_a = 1'b1;
        repeat (54) @(negedge clk);
        line_a = 1'b0;
        repeat (400) @(negedge clk);
        send_bits(0, fr >> 5, 6);
        check_val("maj_data", {24'd0, data_a}, 32'h0);
        check_val("maj_fin", {31'd0, fin_a}, 32'h1);
        check_val("maj_no_perr", np_a - bp, 32'd0);
        ack_a();
`endif

        // after acknowledge the next frame 0x33 loads
        send_bits(0, f8(8'h33, 1'b1), 11);
        check_val("33_data", {24'd0, data_a}, 32'h33);
        check_val("33_fin", {31'd0, fin_a}, 32'h1);

        // 300-clock low glitch on the idle line
        bp = np_a; bf = nf_a; bo = no_a;
        line_a = 1'b0;
        repeat (300) @(negedge clk);
        line_a = 1'b1;
        repeat (1200) @(negedge clk);
        check_val("glitch_no_err", (np_a - bp) + (nf_a - bf) + (no_a - bo), 32'd0);
        check_val("glitch_data", {24'd0, data_a}, 32'h33);
        check_val("glitch_fin", {31'd0, fin_a}, 32'h1);

        // reset asserted in the middle of data bit 4 of 0xA5
        fr = f8(8'hA5, 1'b1);
        send_bits(0, fr, 5);
        line_a = fr[5];
        repeat (432) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_data", {24'd0, data_a}, 32'h0);
        check_val("midrst_fin", {31'd0, fin_a}, 32'h0);
        check_val("midrst_errs", {29'd0, perr_a, ferr_a, ovr_a}, 32'h0);
        repeat (432) @(negedge clk);
        send_bits(0, fr >> 6, 5);
        line_a = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b1;
        bp = np_a; bf = nf_a; bo = no_a;
        repeat (1000) @(negedge clk);
        check_val("postrst_fin", {31'd0, fin_a}, 32'h0);
        check_val("postrst_data", {24'd0, data_a}, 32'h0);
        send_bits(0, fr, 11);
        check_val("a5_data", {24'd0, data_a}, 32'hA5);
        check_val("a5_fin", {31'd0, fin_a}, 32'h1);
        check_val("a5_no_err", (np_a - bp) + (nf_a - bf) + (no_a - bo), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
